// File: rtl/apb_motor_pwm_ramp.sv
// APB3 multi-channel H-bridge PWM with slew-limited duty ramping, reversal through zero and brake.
// PRDATA and HB1/HB2 registered (1 cycle); PREADY tied high, so there is no APB backpressure.
module apb_motor_pwm_ramp #(
  parameter int NUM_CH         = 2,
  parameter int CNT_W          = 20,
  parameter int DUTY_W         = 7,
  parameter int RAMP_W         = 16,
  parameter int DEFAULT_PERIOD = 1000000
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] HB1,
  output logic [NUM_CH-1:0] HB2
);

  typedef enum logic [1:0] {ST_RUN, ST_DECEL, ST_BRAKE} state_e;

  localparam int              PW       = CNT_W + DUTY_W;
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(100);

  logic [CNT_W-1:0]                     period_q, period_d, plat_q, plat_d, cnt_q, cnt_d;
  logic [RAMP_W-1:0]                    rdiv_q, rdiv_d, pre_q, pre_d;
  logic [NUM_CH-1:0][DUTY_W-1:0]        tgt_q, tgt_d, cur_q, cur_d;
  logic [NUM_CH-1:0][CNT_W-1:0]         thr_q, thr_d;
  logic [NUM_CH-1:0]                    fwd_q, fwd_d, brk_q, brk_d, dir_q, dir_d;
  logic [NUM_CH-1:0]                    hb1_q, hb1_d, hb2_q, hb2_d;
  state_e                               st_q [NUM_CH];
  state_e                               st_d [NUM_CH];
  logic [31:0]                          prdata_q, prdata_d;
  logic [5:0]                           idx;
  logic                                 wr_en, rd_en, wrap, tick;
  logic                                 unused_bits;

  assign idx         = PADDR[7:2];
  assign wr_en       = PSEL & PENABLE & PWRITE;
  assign rd_en       = PSEL & ~PWRITE;
  assign wrap        = (cnt_q >= plat_q - CNT_W'(1));
  assign tick        = (pre_q >= rdiv_q);
  assign unused_bits = ^{PADDR[31:8], PADDR[1:0], PWDATA};

  // Threshold for the coming period, sized so CUR=100 yields a constant-high output.
  function automatic logic [CNT_W-1:0] thr_of(input logic [DUTY_W-1:0] c, input logic [CNT_W-1:0] p);
    logic [PW-1:0] prod;
    prod = PW'(c) * PW'(p);
    return CNT_W'(prod / PW'(100));
  endfunction

  always_comb begin
    period_d = period_q;
    rdiv_d   = rdiv_q;
    tgt_d    = tgt_q;
    fwd_d    = fwd_q;
    brk_d    = brk_q;
    if (wr_en) begin
      if (idx == 6'd0)
        period_d = (PWDATA[CNT_W-1:0] < CNT_W'(2)) ? CNT_W'(2) : PWDATA[CNT_W-1:0];
      if (idx == 6'd1)
        rdiv_d = PWDATA[RAMP_W-1:0];
      for (int n = 0; n < NUM_CH; n++) begin
        if (idx == 6'(n + 2)) begin
          tgt_d[n] = (PWDATA[DUTY_W-1:0] > DUTY_MAX) ? DUTY_MAX : PWDATA[DUTY_W-1:0];
          fwd_d[n] = PWDATA[DUTY_W];
          brk_d[n] = PWDATA[DUTY_W+1];
        end
      end
    end
  end

  always_comb begin
    prdata_d = prdata_q;
    if (rd_en) begin
      prdata_d = '0;
      if (idx == 6'd0) prdata_d[CNT_W-1:0]  = period_q;
      if (idx == 6'd1) prdata_d[RAMP_W-1:0] = rdiv_q;
      for (int n = 0; n < NUM_CH; n++) begin
        if (idx == 6'(n + 2)) begin
          prdata_d[DUTY_W-1:0]    = tgt_q[n];
          prdata_d[DUTY_W]        = fwd_q[n];
          prdata_d[DUTY_W+1]      = brk_q[n];
          prdata_d[16 +: DUTY_W]  = cur_q[n];
          prdata_d[24]            = dir_q[n];
        end
      end
    end
  end

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
    plat_d = wrap ? period_q : plat_q;
    pre_d  = tick ? '0 : pre_q + RAMP_W'(1);
  end

  // Per-channel ramp FSM; duty only reaches THR at a wrap, except brake which forces it to 0 at once.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      st_d[n]  = st_q[n];
      cur_d[n] = cur_q[n];
      dir_d[n] = dir_q[n];
      thr_d[n] = wrap ? thr_of(cur_q[n], period_q) : thr_q[n];
      if (brk_q[n]) begin
        st_d[n]  = ST_BRAKE;
        cur_d[n] = '0;
        thr_d[n] = '0;
      end else begin
        unique case (st_q[n])
          ST_RUN: begin
            if (fwd_q[n] != dir_q[n]) begin
              if (cur_q[n] == '0) dir_d[n] = fwd_q[n];
              else                st_d[n]  = ST_DECEL;
            end else if (tick) begin
              if (cur_q[n] < tgt_q[n])      cur_d[n] = cur_q[n] + DUTY_W'(1);
              else if (cur_q[n] > tgt_q[n]) cur_d[n] = cur_q[n] - DUTY_W'(1);
            end
          end
          ST_DECEL: begin
            if (fwd_q[n] == dir_q[n]) begin
              st_d[n] = ST_RUN;
            end else if (cur_q[n] == '0) begin
              dir_d[n] = fwd_q[n];
              st_d[n]  = ST_RUN;
            end else if (tick) begin
              cur_d[n] = cur_q[n] - DUTY_W'(1);
            end
          end
          default: st_d[n] = ST_RUN;
        endcase
      end
      hb1_d[n] = (st_q[n] == ST_BRAKE) | (~dir_q[n] & (cnt_q < thr_q[n]));
      hb2_d[n] = (st_q[n] == ST_BRAKE) | ( dir_q[n] & (cnt_q < thr_q[n]));
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      period_q <= CNT_W'(DEFAULT_PERIOD);
      plat_q   <= CNT_W'(DEFAULT_PERIOD);
      rdiv_q   <= '0;
      cnt_q    <= '0;
      pre_q    <= '0;
      tgt_q    <= '0;
      cur_q    <= '0;
      thr_q    <= '0;
      fwd_q    <= '1;
      dir_q    <= '1;
      brk_q    <= '0;
      hb1_q    <= '0;
      hb2_q    <= '0;
      prdata_q <= '0;
      for (int n = 0; n < NUM_CH; n++) st_q[n] <= ST_RUN;
    end else begin
      period_q <= period_d;
      plat_q   <= plat_d;
      rdiv_q   <= rdiv_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      tgt_q    <= tgt_d;
      cur_q    <= cur_d;
      thr_q    <= thr_d;
      fwd_q    <= fwd_d;
      dir_q    <= dir_d;
      brk_q    <= brk_d;
      hb1_q    <= hb1_d;
      hb2_q    <= hb2_d;
      prdata_q <= prdata_d;
      for (int n = 0; n < NUM_CH; n++) st_q[n] <= st_d[n];
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign HB1     = hb1_q;
  assign HB2     = hb2_q;

endmodule

// File: tb/tb_apb_motor_pwm_ramp.sv
// Bench for apb_motor_pwm_ramp: APB stimulus feeds read/duty scoreboards, drained by independent monitors.
// The reference model tracks settled per-channel state (CUR=TGT, DIR=FWD) and expected duty per period.
module tb_apb_motor_pwm_ramp;
  localparam int NCH  = 2;
  localparam int DEFP = 50;

  logic            PCLK = 1'b0;
  logic            PRESERN = 1'b0;
  logic            PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0]     PADDR = '0, PWDATA = '0;
  logic [31:0]     PRDATA;
  logic            PREADY, PSLVERR;
  logic [NCH-1:0]  HB1, HB2;

  apb_motor_pwm_ramp #(.NUM_CH(NCH), .CNT_W(20), .DUTY_W(7), .RAMP_W(16), .DEFAULT_PERIOD(DEFP)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HB1(HB1), .HB2(HB2));

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [31:0] exp; logic [31:0] mask; bit rng; int lo; int hi; } rd_exp_t;
  typedef struct { int ch; int e1; int e2; int win; } duty_t;
  rd_exp_t rq[$];
  string   rq_nm[$];
  duty_t   dq[$];
  string   dq_nm[$];
  bit      duty_busy = 0;
  bit      allow_both [NCH];
  int      inv_prints = 0;

  int         m_period, m_prev, m_rd, pend;
  logic [6:0] m_tgt [NCH];
  logic [6:0] m_cur [NCH];
  bit         m_fwd [NCH];
  bit         m_brk [NCH];
  bit         m_dir [NCH];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_period = DEFP; m_prev = DEFP; m_rd = 0; pend = 0;
    for (int c = 0; c < NCH; c++) begin
      m_tgt[c] = 0; m_cur[c] = 0; m_fwd[c] = 1; m_brk[c] = 0; m_dir[c] = 1;
    end
  endfunction

  function automatic logic [31:0] exp_ch(input int ch);
    return {7'd0, m_dir[ch], 1'b0, m_cur[ch], 7'd0, m_brk[ch], m_fwd[ch], m_tgt[ch]};
  endfunction

  // Read monitor: every completed APB read is matched against the oldest expectation.
  initial forever begin
    rd_exp_t e;
    string   nm;
    bit      ok;
    @(posedge PCLK);
    if (PSEL && PENABLE && !PWRITE) begin
      #1;
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected actual=%0h required=no_read", PRDATA);
      end else begin
        e  = rq.pop_front();
        nm = rq_nm.pop_front();
        ok = (((PRDATA ^ e.exp) & e.mask) == 32'd0);
        if (e.rng) ok = ok && (int'(PRDATA[23:16]) >= e.lo) && (int'(PRDATA[23:16]) <= e.hi);
        if (!ok) begin
          bad++;
          $display("FAIL %s actual=%0h expected=%0h mask=%0h cur_range=%0d..%0d",
                   nm, PRDATA, e.exp, e.mask, e.lo, e.hi);
        end
      end
    end
  end

  // Duty monitor: counts HB1/HB2 high cycles over one PWM period.
  initial forever begin
    duty_t d;
    string nm;
    int    c1, c2;
    @(posedge PCLK);
    if (dq.size() != 0) begin
      duty_busy = 1;
      d  = dq.pop_front();
      nm = dq_nm.pop_front();
      c1 = 0; c2 = 0;
      repeat (d.win) begin
        @(negedge PCLK);
        c1 += int'(HB1[d.ch]);
        c2 += int'(HB2[d.ch]);
      end
      total++;
      if (c1 != d.e1 || c2 != d.e2) begin
        bad++;
        $display("FAIL %s actual hb1=%0d hb2=%0d expected hb1=%0d hb2=%0d of %0d",
                 nm, c1, c2, d.e1, d.e2, d.win);
      end
      duty_busy = 0;
    end
  end

  // Shoot-through monitor.
  initial forever begin
    @(negedge PCLK);
    for (int c = 0; c < NCH; c++) begin
      total++;
      if (HB1[c] && HB2[c] && !allow_both[c]) begin
        bad++;
        if (inv_prints < 10) begin
          inv_prints++;
          $display("FAIL hb_overlap ch%0d actual=both_high expected=not_both", c);
        end
      end
    end
  end

  task automatic apb_write(input int addr, input logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input int addr, input logic [31:0] exp, input logic [31:0] mask,
                          input bit rng, input int lo, input int hi, input string nm);
    rd_exp_t e;
    e.exp = exp; e.mask = mask; e.rng = rng; e.lo = lo; e.hi = hi;
    rq.push_back(e);
    rq_nm.push_back(nm);
    @(posedge PCLK); #1;
    PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = addr;
    @(posedge PCLK); #1;
    PENABLE = 1;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic read_ch(input int ch, input string nm);
    apb_read(8 + 4*ch, exp_ch(ch), 32'hFFFF_FFFF, 0, 0, 0, nm);
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 8000 && !done; k++) begin
      @(posedge PCLK); #2;
      if (dq.size() == 0 && !duty_busy) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL duty_drain_timeout actual=pending expected=idle");
    end
  endtask

  task automatic duty_ch(input int ch, input string nm);
    duty_t d;
    int    thr;
    thr    = (int'(m_cur[ch]) * m_period) / 100;
    d.ch   = ch;
    d.win  = m_period;
    if (m_brk[ch])      begin d.e1 = m_period; d.e2 = m_period; end
    else if (m_dir[ch]) begin d.e1 = 0;        d.e2 = thr;      end
    else                begin d.e1 = thr;      d.e2 = 0;        end
    dq.push_back(d);
    dq_nm.push_back(nm);
    drain();
  endtask

  task automatic set_period(input int v);
    apb_write(0, v);
    m_prev   = m_period;
    m_period = (v < 2) ? 2 : v;
  endtask

  task automatic set_rd(input int v);
    apb_write(4, v);
    m_rd = v;
  endtask

  task automatic set_ch(input int ch, input int tgt, input bit fwd, input bit brk);
    int t, steps;
    t = (tgt > 100) ? 100 : tgt;
    if (brk)                steps = 0;
    else if (fwd != m_dir[ch]) steps = int'(m_cur[ch]) + t;
    else                    steps = (t > int'(m_cur[ch])) ? t - int'(m_cur[ch]) : int'(m_cur[ch]) - t;
    if (steps > pend) pend = steps;
    apb_write(8 + 4*ch, {22'd0, brk, fwd, 7'(tgt)});
    m_tgt[ch] = 7'(t);
    m_fwd[ch] = fwd;
    m_brk[ch] = brk;
    if (brk) m_cur[ch] = 0;
    else begin m_cur[ch] = 7'(t); m_dir[ch] = fwd; end
  endtask

  task automatic settle();
    repeat ((pend + 3) * (m_rd + 1) + 2*m_prev + 2*m_period + 20) @(posedge PCLK);
    pend   = 0;
    m_prev = m_period;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] e;
    for (int c = 0; c < NCH; c++) allow_both[c] = 0;
    model_reset();

    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_hb1", 32'(HB1), 32'd0);
    chk("rst_hb2", 32'(HB2), 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    @(negedge PCLK);
    PRESERN = 1;

    apb_read(32'h00, DEFP, 32'hFFFF_FFFF, 0, 0, 0, "rst_period");
    apb_read(32'h04, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, "rst_rampdiv");
    read_ch(0, "rst_ch0");
    read_ch(1, "rst_ch1");
    apb_read(32'h3C, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, "unmapped_rd");
    apb_write(32'h3C, 32'hFFFF_FFFF);
    apb_read(32'h04, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, "unmapped_wr");
    #1;
    chk("idle_hb1", 32'(HB1), 32'd0);
    chk("idle_hb2", 32'(HB2), 32'd0);

    // 30% forward at period 100, single-cycle ramp
    set_period(100);
    set_rd(0);
    set_ch(0, 30, 1, 0);
    repeat (30) @(posedge PCLK);
    read_ch(0, "ramp30_cur");
    settle();
    duty_ch(0, "duty30_fwd");

    // slow ramp 0 -> 50 with RAMP_DIV=9
    set_rd(9);
    set_ch(0, 0, 1, 0);
    settle();
    set_ch(0, 50, 1, 0);
    repeat (247) @(posedge PCLK);
    apb_read(32'h08, exp_ch(0), 32'hFF00_FFFF, 1, 23, 26, "ramp_div9_mid");
    settle();
    read_ch(0, "ramp_div9_end");
    duty_ch(0, "duty50_fwd");

    // reversal through zero
    set_rd(0);
    set_ch(0, 40, 1, 0);
    settle();
    set_ch(0, 40, 0, 0);
    e = exp_ch(0);
    e[24] = 1'b1;
    apb_read(32'h08, e, 32'hFF00_FFFF, 1, 30, 40, "decel_mid");
    settle();
    read_ch(0, "reversed_ch0");
    duty_ch(0, "duty40_rev");

    // flip back during deceleration keeps direction
    set_rd(3);
    set_ch(1, 60, 1, 0);
    settle();
    set_ch(1, 60, 0, 0);
    repeat (30) @(posedge PCLK);
    set_ch(1, 60, 1, 0);
    settle();
    read_ch(1, "flipback_ch1");
    duty_ch(1, "duty60_flipback");

    // brake mid-ramp, then release
    set_rd(2);
    set_ch(0, 80, 0, 0);
    repeat (20) @(posedge PCLK);
    allow_both[0] = 1;
    set_ch(0, 80, 0, 1);
    repeat (1) @(posedge PCLK);
    read_ch(0, "brake_ch0");
    duty_ch(0, "duty_brake");
    set_ch(0, 80, 0, 0);
    apb_read(32'h08, exp_ch(0), 32'hFF00_FFFF, 1, 0, 2, "brake_release");
    repeat (5) @(posedge PCLK);
    allow_both[0] = 0;
    settle();
    read_ch(0, "after_brake");
    duty_ch(0, "duty80_rev");

    // clamps
    set_ch(1, 120, 1, 0);
    settle();
    read_ch(1, "tgt_clamp");
    duty_ch(1, "duty100");
    set_period(1);
    apb_read(32'h00, 32'd2, 32'hFFFF_FFFF, 0, 0, 0, "period_clamp");
    settle();
    set_period(100);
    settle();

    // randomized settled operating points
    for (int it = 0; it < 8; it++) begin
      set_period($urandom_range(20, 120));
      set_rd($urandom_range(0, 3));
      for (int c = 0; c < NCH; c++) set_ch(c, $urandom_range(0, 110), 1'($urandom_range(0, 1)), 0);
      settle();
      apb_read(32'h00, m_period, 32'hFFFF_FFFF, 0, 0, 0, "rand_period");
      for (int c = 0; c < NCH; c++) begin
        read_ch(c, "rand_ch");
        duty_ch(c, "rand_duty");
      end
    end

    // asynchronous reset while running at full duty
    set_period(60);
    set_ch(0, 100, 0, 0);
    settle();
    @(posedge PCLK); #3;
    chk("pre_rst_hb1", 32'(HB1[0]), 32'd1);
    PRESERN = 0;
    #1;
    chk("async_rst_hb1", 32'(HB1), 32'd0);
    chk("async_rst_hb2", 32'(HB2), 32'd0);
    chk("async_rst_prdata", PRDATA, 32'd0);
    model_reset();
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESERN = 1;
    read_ch(0, "post_rst_ch0");
    apb_read(32'h00, DEFP, 32'hFFFF_FFFF, 0, 0, 0, "post_rst_period");

    repeat (4) @(posedge PCLK);
    total++;
    if (rq.size() != 0) begin
      bad++;
      $display("FAIL rd_leftover actual=%0d expected=0", rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
